// File: rtl/axi_slave_ram_pkg.sv
// Shared constants and state encodings for the AXI4 slave RAM.
// Burst and response codes, write/read FSM states, and the seed and step
// function of the throttle LFSR.
package axi_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR step for the polynomial x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axi_slave_ram_if.sv
// AXI4 slave bus bundle: AW, W, B, AR and R channels.
//
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where VALID and READY are both high. The source keeps VALID high and its
// payload stable until that edge; READY may change freely.
interface axi_slave_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 28,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     S_AXI_AWID;
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [7:0]          S_AXI_AWLEN;
  logic [1:0]          S_AXI_AWBURST;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;

  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WLAST;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;

  logic [ID_W-1:0]     S_AXI_BID;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;

  logic [ID_W-1:0]     S_AXI_ARID;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [7:0]          S_AXI_ARLEN;
  logic [1:0]          S_AXI_ARBURST;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;

  logic [ID_W-1:0]     S_AXI_RID;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RLAST;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_slave_ram_mem.sv
// Dual-port word RAM with byte enables.
// Port A: AXI beat write plus backdoor load; a load to the same word in the
// same cycle wins and the AXI beat is dropped. Port B: synchronous read whose
// output register holds its value when not enabled, so a read in the same
// cycle as a write to that word returns the old contents.
module axi_slave_ram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                a_we_i,
  input  logic [IW-1:0]       a_addr_i,
  input  logic [DATA_W-1:0]   a_data_i,
  input  logic [DATA_W/8-1:0] a_strb_i,
  input  logic                ld_en_i,
  input  logic [IW-1:0]       ld_addr_i,
  input  logic [DATA_W-1:0]   ld_data_i,
  input  logic                b_en_i,
  input  logic [IW-1:0]       b_addr_i,
  output logic [DATA_W-1:0]   b_dout_o
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              a_keep;

  assign a_keep = a_we_i && !(ld_en_i && (ld_addr_i == a_addr_i));

  // Write port: byte-masked AXI beat, then whole-word backdoor load.
  always_ff @(posedge CLK) begin
    if (a_keep) begin
      for (int i = 0; i < NB; i++) begin
        if (a_strb_i[i]) mem_q[a_addr_i][i*8 +: 8] <= a_data_i[i*8 +: 8];
      end
    end
    if (ld_en_i) mem_q[ld_addr_i] <= ld_data_i;
  end

  // Read port: registered output, cleared by reset, held while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      b_dout_o <= '0;
    end else if (b_en_i) begin
      b_dout_o <= mem_q[b_addr_i];
    end
  end
endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave RAM with FIXED/INCR bursts (WRAP/reserved run as INCR and
// answer SLVERR), configurable read latency and a backdoor load port.
// Optional throttling of AWREADY/WREADY/ARREADY/RVALID-raise by a 16-bit
// LFSR is built when AXI_SLV_THROTTLE_EN is defined.
module axi_slave_ram
  import axi_slave_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 28,
  parameter int DEPTH      = 2048,
  parameter int ID_W       = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  axi_slave_ram_if.slave           s_axi,
  input  logic                     LOAD_EN,
  input  logic [$clog2(DEPTH)-1:0] LOAD_ADDR,
  input  logic [DATA_W-1:0]        LOAD_DATA,
  output w_state_e                 dbg_wstate_o,
  output r_state_e                 dbg_rstate_o
);
  localparam int BSH = $clog2(DATA_W / 8);
  localparam int IW  = $clog2(DEPTH);

  logic aw_gate, w_gate, ar_gate, rv_gate;

`ifdef AXI_SLV_THROTTLE_EN
  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  // Free-running throttle pattern; each gated signal watches its own bit.
  always_ff @(posedge CLK) begin
    if (RST) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_next(lfsr_q);
  end
  assign aw_gate     = lfsr_q[0];
  assign w_gate      = lfsr_q[3];
  assign ar_gate     = lfsr_q[7];
  assign rv_gate     = lfsr_q[11];
  assign unused_lfsr = ^{lfsr_q[15:12], lfsr_q[10:8], lfsr_q[6:4], lfsr_q[2:1]};
`else
  assign aw_gate = 1'b1;
  assign w_gate  = 1'b1;
  assign ar_gate = 1'b1;
  assign rv_gate = 1'b1;
`endif

  // ---------------- write channel ----------------
  w_state_e        w_state_q;
  logic            awready_q, wready_q, bvalid_q;
  logic [1:0]      bresp_q;
  logic [ID_W-1:0] bid_q;
  logic [IW-1:0]   w_addr_q;
  logic [7:0]      w_len_q, w_cnt_q;
  logic            w_fixed_q, w_err_q;
  logic            aw_hs, w_hs, w_last_beat, wlast_bad;

  assign aw_hs       = awready_q && aw_gate && s_axi.S_AXI_AWVALID;
  assign w_hs        = wready_q && w_gate && s_axi.S_AXI_WVALID;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign wlast_bad   = (s_axi.S_AXI_WLAST != w_last_beat);

  // Write FSM: accept address, count beats, then hold the response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s_axi.S_AXI_AWID;
            w_addr_q  <= s_axi.S_AXI_AWADDR[BSH +: IW];
            w_len_q   <= s_axi.S_AXI_AWLEN;
            w_cnt_q   <= '0;
            w_fixed_q <= (s_axi.S_AXI_AWBURST == BURST_FIXED);
            w_err_q   <= s_axi.S_AXI_AWBURST[1];
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_cnt_q <= w_cnt_q + 8'd1;
            if (!w_fixed_q) w_addr_q <= w_addr_q + 1'b1;
            if (wlast_bad) w_err_q <= 1'b1;
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q && aw_gate;
  assign s_axi.S_AXI_WREADY  = wready_q && w_gate;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_BID     = bid_q;

  // ---------------- read channel ----------------
  r_state_e        r_state_q;
  logic            arready_q, rvalid_q, rlast_q;
  logic [1:0]      rresp_q;
  logic [ID_W-1:0] rid_q;
  logic [IW-1:0]   r_addr_q, r_next, ar_idx, b_addr;
  logic [7:0]      r_len_q, r_cnt_q;
  logic [3:0]      r_wait_q;
  logic            r_fixed_q, ar_hs, r_hs, b_en;

  assign ar_hs  = arready_q && ar_gate && s_axi.S_AXI_ARVALID;
  assign r_hs   = rvalid_q && s_axi.S_AXI_RREADY;
  assign r_next = r_fixed_q ? r_addr_q : r_addr_q + 1'b1;
  assign ar_idx = s_axi.S_AXI_ARADDR[BSH +: IW];

  // RAM read port: fetch exactly when a beat is about to become valid.
  always_comb begin
    b_en   = 1'b0;
    b_addr = r_addr_q;
    case (r_state_q)
      R_IDLE: begin
        b_addr = ar_idx;
        b_en   = ar_hs && (RD_LATENCY == 1) && rv_gate;
      end
      R_WAIT: b_en = (r_wait_q == 4'd1) && rv_gate;
      R_DATA: begin
        if (rvalid_q) begin
          b_addr = r_next;
          b_en   = r_hs && !rlast_q && rv_gate;
        end else begin
          b_en = rv_gate;
        end
      end
      default: b_en = 1'b0;
    endcase
  end

  // Read FSM: latch the request, wait out the latency, stream the beats.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_wait_q  <= '0;
      r_fixed_q <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rid_q     <= s_axi.S_AXI_ARID;
            r_addr_q  <= ar_idx;
            r_len_q   <= s_axi.S_AXI_ARLEN;
            r_cnt_q   <= '0;
            r_fixed_q <= (s_axi.S_AXI_ARBURST == BURST_FIXED);
            rresp_q   <= s_axi.S_AXI_ARBURST[1] ? RESP_SLVERR : RESP_OKAY;
            if (RD_LATENCY == 1) begin
              rvalid_q  <= rv_gate;
              rlast_q   <= (s_axi.S_AXI_ARLEN == 8'd0);
              r_state_q <= R_DATA;
            end else begin
              r_wait_q  <= 4'(RD_LATENCY - 1);
              r_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_wait_q == 4'd1) begin
            rvalid_q  <= rv_gate;
            rlast_q   <= (r_cnt_q == r_len_q);
            r_state_q <= R_DATA;
          end else begin
            r_wait_q <= r_wait_q - 4'd1;
          end
        end
        R_DATA: begin
          if (rvalid_q) begin
            if (r_hs) begin
              if (rlast_q) begin
                rvalid_q  <= 1'b0;
                rlast_q   <= 1'b0;
                r_state_q <= R_IDLE;
              end else begin
                r_addr_q <= r_next;
                r_cnt_q  <= r_cnt_q + 8'd1;
                rvalid_q <= rv_gate;
                rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
              end
            end
          end else if (rv_gate) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (r_cnt_q == r_len_q);
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_ARREADY = arready_q && ar_gate;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RID     = rid_q;

  // Word offset and out-of-range address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

  axi_slave_ram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_mem (
    .CLK       (CLK),
    .RST       (RST),
    .a_we_i    (w_hs && !RST),
    .a_addr_i  (w_addr_q),
    .a_data_i  (s_axi.S_AXI_WDATA),
    .a_strb_i  (s_axi.S_AXI_WSTRB),
    .ld_en_i   (LOAD_EN),
    .ld_addr_i (LOAD_ADDR),
    .ld_data_i (LOAD_DATA),
    .b_en_i    (b_en && !RST),
    .b_addr_i  (b_addr),
    .b_dout_o  (s_axi.S_AXI_RDATA)
  );

  assign dbg_wstate_o = w_state_q;
  assign dbg_rstate_o = r_state_q;
endmodule
